// File: rtl/instr_sequencer.sv
// instr_sequencer: 16-entry program memory feeding a FETCH/DECODE/WRITEBACK
// sequencer that drives register-file addresses and ALU controls downstream.
// Every output is a register; the program memory is writable only while the
// sequencer is parked in IDLE or DONE.
`timescale 1ns/1ps

module instr_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [3:0]  load_addr,
  input  logic [20:0] load_data,
  input  logic        start,
  output logic [3:0]  RA1,
  output logic [3:0]  RA2,
  output logic [3:0]  WA,
  output logic [7:0]  external_data_in,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  pc,
  output logic        busy,
  output logic        done
);

  // Instruction word layout, MSB first.
  typedef struct packed {
    logic       halt;
    logic       we;
    logic       alu_src;
    logic [1:0] alu_ctl;
    logic [3:0] wa;
    logic [3:0] ra1;
    logic [7:0] imm;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WRITEBACK,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_ADDR = 4'hF;

  state_t      r_state;
  instr_t      r_ir;
  logic [20:0] r_mem [16];

  logic w_parked;
  logic w_mem_we;

  // Loads and restarts are only honoured while no program is running.
  assign w_parked = (r_state == S_IDLE) || (r_state == S_DONE);
  // Reset outranks a load on the same edge.
  assign w_mem_we = reset && w_parked && load_en;

  // Program memory write port.
  // NOTE: the memory has no reset branch on purpose -- reset must leave the
  // loaded program intact, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[load_addr] <= load_data;
    end
  end

  // Sequencer FSM with all outputs registered alongside the state.
  // NOTE: every state/output register is assigned with <= so all of them
  // update together from the pre-edge values; a blocking = here would let
  // later statements see half-updated state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_ir             <= '0;
      pc               <= '0;
      RA1              <= '0;
      RA2              <= '0;
      WA               <= '0;
      external_data_in <= '0;
      RegWrite         <= 1'b0;
      ALUSrc           <= 1'b0;
      ALUControl       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // A load on this same edge lands in memory before the FETCH reads it.
          if (start) begin
            pc      <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            r_state <= S_FETCH;
          end
        end

        S_FETCH: begin
          r_ir     <= instr_t'(r_mem[pc]);
          RegWrite <= 1'b0;
          r_state  <= S_DECODE;
        end

        S_DECODE: begin
          if (r_ir.halt) begin
            // Halt retires without a write and leaves pc on the halt word.
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            // Fields become visible during WRITEBACK, which is exactly
            // the cycle the write strobe is high.
            RA1              <= r_ir.ra1;
            RA2              <= r_ir.imm[3:0];
            WA               <= r_ir.wa;
            external_data_in <= r_ir.imm;
            ALUSrc           <= r_ir.alu_src;
            ALUControl       <= r_ir.alu_ctl;
            RegWrite         <= r_ir.we;
            r_state          <= S_WRITEBACK;
          end
        end

        S_WRITEBACK: begin
          RegWrite <= 1'b0;
          if (pc == LAST_ADDR) begin
            // Falling off the end of memory is an implicit halt; pc stays put.
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            pc      <= pc + 4'd1;
            r_state <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: a trace-building program model predicts every
// output on every cycle, and per-scenario literal expectations pin the model.
`timescale 1ns/1ps

module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [20:0] load_data = '0;
  logic        start = 1'b0;
  logic [3:0]  RA1, RA2, WA;
  logic [7:0]  external_data_in;
  logic        RegWrite, ALUSrc;
  logic [1:0]  ALUControl;
  logic [3:0]  pc;
  logic        busy, done;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .load_en          (load_en),
    .load_addr        (load_addr),
    .load_data        (load_data),
    .start            (start),
    .RA1              (RA1),
    .RA2              (RA2),
    .WA               (WA),
    .external_data_in (external_data_in),
    .RegWrite         (RegWrite),
    .ALUSrc           (ALUSrc),
    .ALUControl       (ALUControl),
    .pc               (pc),
    .busy             (busy),
    .done             (done)
  );

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa;
    logic [7:0] ext;
    logic       rw;
    logic       src;
    logic [1:0] ctl;
    logic [3:0] pc;
    logic       busy;
    logic       done;
  } obs_t;

  localparam logic [20:0] HALT = 21'h100000;

  obs_t dut_obs;
  assign dut_obs = {RA1, RA2, WA, external_data_in, RegWrite, ALUSrc,
                    ALUControl, pc, busy, done};

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [20:0] ins(input bit we, input bit src,
                                      input logic [1:0] ctl,
                                      input logic [3:0] wa,
                                      input logic [3:0] ra1,
                                      input logic [7:0] imm);
    return {1'b0, we, src, ctl, wa, ra1, imm};
  endfunction

  // ---------------- Program-level model ----------------
  // On an accepted start the whole run is unrolled into a queue of per-cycle
  // expected outputs: two quiet cycles per instruction, then either the halt
  // (done) or one cycle showing the instruction's fields and write strobe.
  logic [20:0] m_mem [16];
  obs_t        m_exp;
  obs_t        m_trace [$];

  function automatic void build_trace();
    obs_t        cur;
    logic [20:0] w;
    cur      = m_exp;
    cur.pc   = 4'd0;
    cur.busy = 1'b1;
    cur.done = 1'b0;
    cur.rw   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w = m_mem[i];
      m_trace.push_back(cur);
      m_trace.push_back(cur);
      if (w[20]) begin
        cur.busy = 1'b0;
        cur.done = 1'b1;
        m_trace.push_back(cur);
        break;
      end
      cur.rw  = w[19];
      cur.src = w[18];
      cur.ctl = w[17:16];
      cur.wa  = w[15:12];
      cur.ra1 = w[11:8];
      cur.ext = w[7:0];
      cur.ra2 = w[3:0];
      m_trace.push_back(cur);
      cur.rw = 1'b0;
      if (i == 15) begin
        cur.busy = 1'b0;
        cur.done = 1'b1;
        m_trace.push_back(cur);
      end else begin
        cur.pc = 4'(i + 1);
      end
    end
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_exp = '0;
      m_trace.delete();
    end else if (m_trace.size() != 0) begin
      m_exp = m_trace.pop_front();
    end else begin
      if (load_en) m_mem[load_addr] = load_data;
      if (start) begin
        build_trace();
        m_exp = m_trace.pop_front();
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) check("cycle", 32'(dut_obs), 32'(m_exp));
  end

  // ---------------- Stimulus helpers ----------------
  task automatic load(input logic [3:0] a, input logic [20:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  int   cycles, rw_count, rw_cycle, done_cycle;
  obs_t rw_snap;

  // Pulse start (optionally with a same-edge load), then watch until done.
  // cycles counts clock edges after the one that accepted start.
  // poke re-pulses start and a load of HALT to address 0 while busy.
  task automatic run_prog(input bit with_load, input logic [3:0] la,
                          input logic [20:0] ld, input bit poke);
    @(negedge clk);
    start = 1'b1;
    if (with_load) begin
      load_en   = 1'b1;
      load_addr = la;
      load_data = ld;
    end
    @(negedge clk);
    start      = 1'b0;
    load_en    = 1'b0;
    cycles     = 0;
    rw_count   = 0;
    rw_cycle   = -1;
    done_cycle = -1;
    rw_snap    = '0;
    while (cycles < 200) begin
      if (RegWrite) begin
        rw_count++;
        rw_snap = dut_obs;
        if (rw_cycle < 0) rw_cycle = cycles;
      end
      if (done) begin
        done_cycle = cycles;
        break;
      end
      if (poke && (cycles == 4 || cycles == 7)) begin
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = HALT;
      end else begin
        start   = 1'b0;
        load_en = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start   = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic load_add_prog();
    load(4'd0, ins(1'b1, 1'b1, 2'b00, 4'd5, 4'd0, 8'h05));
    load(4'd1, ins(1'b1, 1'b1, 2'b00, 4'd4, 4'd0, 8'h04));
    load(4'd2, ins(1'b1, 1'b0, 2'b10, 4'd6, 4'd5, 8'h04));
    load(4'd3, HALT);
  endtask

  task automatic check_add_prog(input string tag);
    check({tag, "_rw_count"}, 32'(rw_count), 32'd3);
    check({tag, "_ra1"}, 32'(rw_snap.ra1), 32'd5);
    check({tag, "_ra2"}, 32'(rw_snap.ra2), 32'd4);
    check({tag, "_wa"}, 32'(rw_snap.wa), 32'd6);
    check({tag, "_aluctl"}, 32'(rw_snap.ctl), 32'd2);
    check({tag, "_done_cycle"}, 32'(done_cycle), 32'd11);
    check({tag, "_pc"}, 32'(pc), 32'd3);
  endtask

  // ---------------- Directed scenarios ----------------
  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_state", 32'(dut_obs), 32'd0);
    reset = 1'b1;

    // Single immediate write followed by halt.
    load(4'd0, ins(1'b1, 1'b1, 2'b00, 4'd1, 4'd0, 8'h05));
    load(4'd1, HALT);
    run_prog(1'b0, 4'd0, '0, 1'b0);
    check("imm_rw_count", 32'(rw_count), 32'd1);
    check("imm_rw_cycle", 32'(rw_cycle), 32'd2);
    check("imm_wa", 32'(rw_snap.wa), 32'd1);
    check("imm_alusrc", 32'(rw_snap.src), 32'd1);
    check("imm_ext", 32'(rw_snap.ext), 32'h05);
    check("imm_done_cycle", 32'(done_cycle), 32'd5);
    check("imm_pc", 32'(pc), 32'd1);
    check("imm_busy", 32'(busy), 32'd0);

    // Two immediate loads then a register-register add, then halt.
    load_add_prog();
    run_prog(1'b0, 4'd0, '0, 1'b0);
    check_add_prog("add");

    // we=0 instruction produces no strobe but pc still advances.
    load(4'd0, ins(1'b0, 1'b0, 2'b11, 4'd7, 4'd2, 8'h33));
    load(4'd1, ins(1'b1, 1'b1, 2'b01, 4'd8, 4'd1, 8'h12));
    load(4'd2, HALT);
    run_prog(1'b0, 4'd0, '0, 1'b0);
    check("nowe_rw_count", 32'(rw_count), 32'd1);
    check("nowe_wa", 32'(rw_snap.wa), 32'd8);
    check("nowe_done_cycle", 32'(done_cycle), 32'd8);
    check("nowe_pc", 32'(pc), 32'd2);

    // Full memory without halt: implicit halt at address 15, no wrap.
    for (int i = 0; i < 16; i++) begin
      load(4'(i), ins(1'(i % 2), 1'(i % 3 == 0), 2'(i), 4'(i), 4'(15 - i),
                      8'(i * 3)));
    end
    run_prog(1'b0, 4'd0, '0, 1'b0);
    check("full_done_cycle", 32'(done_cycle), 32'd48);
    check("full_pc", 32'(pc), 32'd15);
    check("full_rw_count", 32'(rw_count), 32'd8);
    check("full_last_wa", 32'(rw_snap.wa), 32'd15);

    // Load and start on the same edge from DONE: new word is executed.
    load(4'd1, HALT);
    run_prog(1'b1, 4'd0, ins(1'b1, 1'b0, 2'b11, 4'd9, 4'd3, 8'h07), 1'b0);
    check("ldst_rw_count", 32'(rw_count), 32'd1);
    check("ldst_wa", 32'(rw_snap.wa), 32'd9);
    check("ldst_ra2", 32'(rw_snap.ra2), 32'd7);
    check("ldst_aluctl", 32'(rw_snap.ctl), 32'd3);
    check("ldst_done_cycle", 32'(done_cycle), 32'd5);

    // Reset during DECODE of the second instruction, then a clean rerun.
    load_add_prog();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_pc", 32'(pc), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_state", 32'(dut_obs), 32'd0);
    reset = 1'b1;
    run_prog(1'b0, 4'd0, '0, 1'b0);
    check_add_prog("rerun");

    // start/load pulses while busy are ignored; memory survives them.
    run_prog(1'b0, 4'd0, '0, 1'b1);
    check_add_prog("poke");
    run_prog(1'b0, 4'd0, '0, 1'b0);
    check_add_prog("after_poke");

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
